// File: rtl/idft_mem_server_pkg.sv
`default_nettype none
// ============================================================================
// Module      : idft_mem_server_pkg
// Description : Shared widths, buffer depth and FSM encoding for the IDFT
//               memory server and its sample buffers.
// Revision    : 1.0 - initial release
// ============================================================================
package idft_mem_server_pkg;

    localparam int c_DW    = 32;
    localparam int c_AW    = 3;
    localparam int c_DEPTH = 2 ** c_AW;

    // Run-control FSM encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

endpackage : idft_mem_server_pkg
`default_nettype wire

// File: rtl/idft_sample_ram.sv
`default_nettype none
// ============================================================================
// Module      : idft_sample_ram
// Description : Simple dual-port sample buffer, one synchronous write port and
//               one registered, enabled read port. Read-during-write to the
//               same address returns the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
module idft_sample_ram #(
    parameter int DW = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int c_DEPTH = 2 ** AW;

    // Storage is deliberately left out of reset so buffered samples survive it
    logic [DW-1:0] r_mem [c_DEPTH];
    logic [DW-1:0] r_rdata;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read port; only the output register is cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule : idft_sample_ram
`default_nettype wire

// File: rtl/idft_mem_server.sv
`default_nettype none
// ============================================================================
// Module      : idft_mem_server
// Description : Memory-side responder for the IDFT core. Serves core reads
//               from the host-loaded input buffer with a data_ok pulse,
//               captures write-backs into the result buffer, runs the core
//               and flags protocol errors.
// Revision    : 1.0 - initial release
// ============================================================================
module idft_mem_server
    import idft_mem_server_pkg::*;
#(
    parameter int DW       = c_DW,
    parameter int AW       = c_AW,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata_real,
    input  logic [DW-1:0] host_wdata_imag,
    input  logic          host_go,
    input  logic          host_ack,
    input  logic [AW-1:0] host_raddr,
    output logic [DW-1:0] host_rdata_real,
    output logic [DW-1:0] host_rdata_imag,
    output logic          busy,
    output logic          all_done,
    output logic          err,
    output logic          core_start,
    input  logic          core_done,
    input  logic          ri_real,
    input  logic          ri_imag,
    input  logic          wi_real,
    input  logic          wi_imag,
    input  logic [AW-1:0] addr_in,
    output logic          data_ok,
    output logic [DW-1:0] x_real_out,
    output logic [DW-1:0] x_imag_out,
    input  logic [DW-1:0] X_real_in,
    input  logic [DW-1:0] X_imag_in
);

    localparam logic [AW-1:0] c_LAST_ADDR = {AW{1'b1}};

    logic [1:0]          r_state;
    logic [READ_LAT-1:0] r_lat_sr;
    logic [AW-1:0]       r_req_addr;
    logic [AW-1:0]       r_wr_count;
    logic                r_wr_wrap;
    logic                r_err;
    logic                r_data_ok;

    logic          w_run;
    logic          w_host_wr;
    logic          w_rd_req;
    logic          w_pending;
    logic          w_rd_accept;
    logic          w_rd_drop;
    logic          w_rd_bad;
    logic          w_resp;
    logic          w_wb;
    logic          w_wb_bad;
    logic          w_launch;
    logic          w_finish;
    logic [AW-1:0] w_wr_count_nxt;
    logic          w_wrap_nxt;
    logic          w_count_bad;

    assign w_run       = (r_state == c_ST_RUN);
    assign w_host_wr   = host_we & ((r_state == c_ST_IDLE) | (r_state == c_ST_DONE));
    assign w_rd_req    = w_run & ri_real & ri_imag;
    assign w_pending   = |r_lat_sr;
    assign w_rd_accept = w_rd_req & ~w_pending;
    assign w_rd_drop   = w_rd_req & w_pending;
    assign w_rd_bad    = w_run & (ri_real ^ ri_imag);
    assign w_resp      = w_run & r_lat_sr[READ_LAT-1];
    assign w_wb        = w_run & wi_real & wi_imag;
    assign w_wb_bad    = w_run & (wi_real ^ wi_imag);
    assign w_launch    = (r_state == c_ST_IDLE) & host_go;
    assign w_finish    = w_run & core_done;

    // A full pass is a wrap of the write counter back to zero; a write landing
    // on the same edge as core_done still counts towards the pass.
    assign w_wr_count_nxt = r_wr_count + AW'(w_wb);
    assign w_wrap_nxt     = r_wr_wrap | (w_wb & (r_wr_count == c_LAST_ADDR));
    assign w_count_bad    = ~(w_wrap_nxt & (w_wr_count_nxt == '0));

    // Run-control FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: if (host_go)   r_state <= c_ST_RUN;
                c_ST_RUN:  if (core_done) r_state <= c_ST_DONE;
                c_ST_DONE: if (host_ack)  r_state <= c_ST_IDLE;
                default:                  r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Read-request latency pipe; a set bit anywhere means a request is in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lat_sr   <= '0;
            r_req_addr <= '0;
            r_data_ok  <= 1'b0;
        end else begin
            r_data_ok <= w_resp;
            if (w_run) begin
                r_lat_sr <= (r_lat_sr << 1) | READ_LAT'(w_rd_accept);
            end else begin
                r_lat_sr <= '0;
            end
            if (w_rd_accept) begin
                r_req_addr <= addr_in;
            end
        end
    end

    // Write-back counter and sticky protocol error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_count <= '0;
            r_wr_wrap  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_launch) begin
                r_wr_count <= '0;
                r_wr_wrap  <= 1'b0;
            end else begin
                r_wr_count <= w_wr_count_nxt;
                r_wr_wrap  <= w_wrap_nxt;
            end
            r_err <= r_err | w_rd_drop | w_rd_bad | w_wb_bad | (w_finish & w_count_bad);
        end
    end

    assign busy       = w_run;
    assign core_start = w_run;
    assign all_done   = (r_state == c_ST_DONE);
    assign err        = r_err;
    assign data_ok    = r_data_ok;

    // Input buffer: host writes, core reads (read register doubles as x_*_out)
    idft_sample_ram #(.DW(DW), .AW(AW)) u_in_real (
        .clk   (clk),
        .rst   (rst),
        .we    (w_host_wr),
        .waddr (host_addr),
        .wdata (host_wdata_real),
        .re    (w_resp),
        .raddr (r_req_addr),
        .rdata (x_real_out)
    );

    idft_sample_ram #(.DW(DW), .AW(AW)) u_in_imag (
        .clk   (clk),
        .rst   (rst),
        .we    (w_host_wr),
        .waddr (host_addr),
        .wdata (host_wdata_imag),
        .re    (w_resp),
        .raddr (r_req_addr),
        .rdata (x_imag_out)
    );

    // Result buffer: core writes back, host reads at any time
    idft_sample_ram #(.DW(DW), .AW(AW)) u_res_real (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wb),
        .waddr (addr_in),
        .wdata (X_real_in),
        .re    (1'b1),
        .raddr (host_raddr),
        .rdata (host_rdata_real)
    );

    idft_sample_ram #(.DW(DW), .AW(AW)) u_res_imag (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wb),
        .waddr (addr_in),
        .wdata (X_imag_in),
        .re    (1'b1),
        .raddr (host_raddr),
        .rdata (host_rdata_imag)
    );

endmodule : idft_mem_server
`default_nettype wire

// File: tb/tb_idft_mem_server.sv
`default_nettype none
// ============================================================================
// Module      : tb_idft_mem_server
// Description : Self-checking bench for idft_mem_server with a behavioural
//               core, randomized sample data and an array-based buffer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idft_mem_server;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata_real;
    logic [DW-1:0] host_wdata_imag;
    logic          host_go;
    logic          host_ack;
    logic [AW-1:0] host_raddr;
    logic [DW-1:0] host_rdata_real;
    logic [DW-1:0] host_rdata_imag;
    logic          busy;
    logic          all_done;
    logic          err;
    logic          core_start;
    logic          core_done;
    logic          ri_real;
    logic          ri_imag;
    logic          wi_real;
    logic          wi_imag;
    logic [AW-1:0] addr_in;
    logic          data_ok;
    logic [DW-1:0] x_real_out;
    logic [DW-1:0] x_imag_out;
    logic [DW-1:0] X_real_in;
    logic [DW-1:0] X_imag_in;

    idft_mem_server #(.DW(DW), .AW(AW), .READ_LAT(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .host_we         (host_we),
        .host_addr       (host_addr),
        .host_wdata_real (host_wdata_real),
        .host_wdata_imag (host_wdata_imag),
        .host_go         (host_go),
        .host_ack        (host_ack),
        .host_raddr      (host_raddr),
        .host_rdata_real (host_rdata_real),
        .host_rdata_imag (host_rdata_imag),
        .busy            (busy),
        .all_done        (all_done),
        .err             (err),
        .core_start      (core_start),
        .core_done       (core_done),
        .ri_real         (ri_real),
        .ri_imag         (ri_imag),
        .wi_real         (wi_real),
        .wi_imag         (wi_imag),
        .addr_in         (addr_in),
        .data_ok         (data_ok),
        .x_real_out      (x_real_out),
        .x_imag_out      (x_imag_out),
        .X_real_in       (X_real_in),
        .X_imag_in       (X_imag_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: buffer contents and whether a run is in progress
    logic [DW-1:0] m_in_re  [DEPTH];
    logic [DW-1:0] m_in_im  [DEPTH];
    logic [DW-1:0] m_res_re [DEPTH];
    logic [DW-1:0] m_res_im [DEPTH];
    bit            m_running;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge
    task automatic host_load(input int a, input logic [DW-1:0] r, input logic [DW-1:0] i);
        host_we = 1'b1; host_addr = AW'(a); host_wdata_real = r; host_wdata_imag = i;
        @(negedge clk);
        host_we = 1'b0;
        if (!m_running) begin
            m_in_re[a] = r;
            m_in_im[a] = i;
        end
    endtask

    task automatic host_read(input int a, output logic [DW-1:0] r, output logic [DW-1:0] i);
        host_raddr = AW'(a);
        @(negedge clk);
        r = host_rdata_real;
        i = host_rdata_imag;
    endtask

    task automatic go();
        host_go = 1'b1;
        @(negedge clk);
        host_go = 1'b0;
        m_running = 1'b1;
    endtask

    task automatic finish_run();
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        m_running = 1'b0;
    endtask

    task automatic ack();
        host_ack = 1'b1;
        @(negedge clk);
        host_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_running = 1'b0;
        @(negedge clk);
    endtask

    // Behavioural core read: request, then wait (bounded) for data_ok.
    // Sampling edge follows the drive; data_ok becomes visible at the falling
    // edge after READ_LAT further rising edges.
    task automatic core_read(input int a, output logic [DW-1:0] dr, output logic [DW-1:0] di);
        int n;
        ri_real = 1'b1; ri_imag = 1'b1; addr_in = AW'(a);
        @(negedge clk);
        n = 1;
        ri_real = 1'b0; ri_imag = 1'b0;
        while (!data_ok && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rd_lat", 64'(n), 64'(LAT + 1));
        dr = x_real_out;
        di = x_imag_out;
        @(negedge clk);
        chk("rd_pulse", 64'(data_ok), 64'd0);
        chk("rd_hold", {x_real_out, x_imag_out}, {dr, di});
    endtask

    task automatic core_write(input int a, input logic [DW-1:0] r, input logic [DW-1:0] i);
        wi_real = 1'b1; wi_imag = 1'b1; addr_in = AW'(a);
        X_real_in = r; X_imag_in = i;
        @(negedge clk);
        wi_real = 1'b0; wi_imag = 1'b0;
        if (m_running) begin
            m_res_re[a] = r;
            m_res_im[a] = i;
        end
    endtask

    // Count data_ok pulses over a window of falling edges
    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (data_ok) pulses++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] dr, di, rr, ri;
        int            pulses;
        int            a;

        rst = 1'b0; m_running = 1'b0;
        host_we = 0; host_addr = 0; host_wdata_real = 0; host_wdata_imag = 0;
        host_go = 0; host_ack = 0; host_raddr = 0; core_done = 0;
        ri_real = 0; ri_imag = 0; wi_real = 0; wi_imag = 0; addr_in = 0;
        X_real_in = 0; X_imag_in = 0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(all_done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_start", 64'(core_start), 64'd0);
        chk("rst_dok", 64'(data_ok), 64'd0);
        chk("rst_xout", {x_real_out, x_imag_out}, 64'd0);
        chk("rst_hrd", {host_rdata_real, host_rdata_imag}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed pass: load known ramp, core writes halved samples back
        for (int k = 0; k < DEPTH; k++) host_load(k, 32'h100 * (k + 1), 32'h10 * (k + 1));
        go();
        chk("run_busy", 64'(busy), 64'd1);
        chk("run_start", 64'(core_start), 64'd1);
        for (int k = 0; k < DEPTH; k++) begin
            core_read(k, dr, di);
            chk("ramp_rd", {dr, di}, {m_in_re[k], m_in_im[k]});
            core_write(k, dr >> 1, di >> 1);
        end
        finish_run();
        chk("ramp_done", 64'(all_done), 64'd1);
        chk("ramp_busy", 64'(busy), 64'd0);
        chk("ramp_err", 64'(err), 64'd0);
        for (int k = 0; k < DEPTH; k++) begin
            host_read(k, rr, ri);
            chk("ramp_res", {rr, ri}, {32'h80 * (k + 1), 32'h8 * (k + 1)});
        end
        // host_go in DONE must be ignored
        go();
        m_running = 1'b0;
        chk("done_go_ign", 64'({all_done, busy}), 64'b10);
        ack();
        chk("ack_idle", 64'({all_done, busy}), 64'b00);

        // Randomized passes with random addresses, gaps and write data
        for (int round = 0; round < 3; round++) begin
            for (int k = 0; k < DEPTH; k++) host_load(k, $urandom, $urandom);
            go();
            if (round == 0) begin
                host_load(2, $urandom, $urandom);
                core_read(2, dr, di);
                chk("run_we_ign", {dr, di}, {m_in_re[2], m_in_im[2]});
            end
            for (int k = 0; k < DEPTH; k++) begin
                a = $urandom_range(0, DEPTH - 1);
                core_read(a, dr, di);
                chk("rnd_rd", {dr, di}, {m_in_re[a], m_in_im[a]});
                repeat ($urandom_range(0, 2)) @(negedge clk);
                core_write(a, (dr >> 1) ^ $urandom, di + $urandom);
            end
            finish_run();
            chk("rnd_done", 64'(all_done), 64'd1);
            chk("rnd_err", 64'(err), 64'd0);
            for (int k = 0; k < DEPTH; k++) begin
                host_read(k, rr, ri);
                chk("rnd_res", {rr, ri}, {m_res_re[k], m_res_im[k]});
            end
            ack();
            if (round == 0) begin
                host_load(2, 32'hCAFE_0002, 32'hBEEF_0002);
                go();
                core_read(2, dr, di);
                chk("idle_we_ok", {dr, di}, {32'hCAFE_0002, 32'hBEEF_0002});
                for (int k = 0; k < DEPTH; k++) core_write(k, m_res_re[k], m_res_im[k]);
                finish_run();
                ack();
            end
        end
        chk("rnd_err_end", 64'(err), 64'd0);

        // Second request while one is pending: one response, sticky err
        go();
        ri_real = 1; ri_imag = 1; addr_in = 3'd1;
        @(negedge clk);
        addr_in = 3'd4;
        @(negedge clk);
        ri_real = 0; ri_imag = 0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (data_ok) begin
                pulses++;
                chk("dbl_data", {x_real_out, x_imag_out}, {m_in_re[1], m_in_im[1]});
            end
        end
        chk("dbl_pulses", 64'(pulses), 64'd1);
        chk("dbl_err", 64'(err), 64'd1);
        repeat (5) @(negedge clk);
        chk("dbl_err_sticky", 64'(err), 64'd1);
        do_reset();
        chk("rst_err_clr", 64'(err), 64'd0);

        // Mismatched read strobes: not served, err
        go();
        ri_real = 1; ri_imag = 0; addr_in = 3'd3;
        @(negedge clk);
        ri_real = 0;
        count_pulses(10, pulses);
        chk("ri_mis_pulses", 64'(pulses), 64'd0);
        chk("ri_mis_err", 64'(err), 64'd1);
        do_reset();

        // Early completion after six write-backs
        go();
        for (int k = 0; k < 6; k++) core_write(k, $urandom, $urandom);
        finish_run();
        chk("short_done", 64'(all_done), 64'd1);
        chk("short_err", 64'(err), 64'd1);
        do_reset();

        // Asynchronous reset in the middle of a run with a response in flight
        go();
        for (int k = 0; k < 3; k++) core_write(k, $urandom, $urandom);
        ri_real = 1; ri_imag = 1; addr_in = 3'd6;
        @(negedge clk);
        ri_real = 0; ri_imag = 0;
        pulses = 0;
        while (!data_ok && pulses < 20) begin
            @(negedge clk);
            pulses++;
        end
        chk("mid_dok_seen", 64'(data_ok), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_async", 64'({core_start, busy, data_ok}), 64'b000);
        @(negedge clk);
        rst = 1'b1;
        m_running = 1'b0;
        @(negedge clk);
        chk("mid_idle", 64'({all_done, busy}), 64'b00);
        for (int k = 0; k < 3; k++) begin
            host_read(k, rr, ri);
            chk("mid_keep", {rr, ri}, {m_res_re[k], m_res_im[k]});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_idft_mem_server
`default_nettype wire

// File: doc/idft_mem_server.md
Name: idft_mem_server

Overview:
- Memory-side responder for the IDFT core's request interface.
- Holds an 8-entry real/imag input sample buffer loaded by the host and serves the core's read requests with a data_ok pulse.
- Captures the core's write-backs into an 8-entry result buffer.
- Runs the core via core_start and reports completion and protocol errors back to the host.

Parameters:
- DW, 32, sample width (real and imag each)
- AW, 3, address width; buffer depth is 2**AW = 8
- READ_LAT, 1, cycles from a sampled read request to data_ok; legal range 1..4

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset; 0 = reset
- host_we  in  1  write host_wdata_* into the input buffer at host_addr
- host_addr  in  AW  input buffer write address
- host_wdata_real  in  DW  input sample, real part
- host_wdata_imag  in  DW  input sample, imag part
- host_go  in  1  launch a run
- host_ack  in  1  acknowledge completion; returns the block to IDLE
- host_raddr  in  AW  result buffer read address
- host_rdata_real  out  DW  result buffer real part, registered
- host_rdata_imag  out  DW  result buffer imag part, registered
- busy  out  1  high in RUN
- all_done  out  1  high in DONE
- err  out  1  sticky protocol error flag
- core_start  out  1  run enable to the core
- core_done  in  1  core finished
- ri_real  in  1  core read request, real part
- ri_imag  in  1  core read request, imag part
- wi_real  in  1  core write strobe, real part
- wi_imag  in  1  core write strobe, imag part
- addr_in  in  AW  core address, used for both reads and writes
- data_ok  out  1  read data valid, single-cycle pulse
- x_real_out  out  DW  read data to core, real part
- x_imag_out  out  DW  read data to core, imag part
- X_real_in  in  DW  write data from core, real part
- X_imag_in  in  DW  write data from core, imag part

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0; FSM goes to IDLE; counters and err clear.
  - Buffer contents are not reset.
- FSM states:
  - IDLE: host_go -> RUN.
  - RUN: core_start=1, busy=1. core_done=1 -> DONE; core_start drops on the same edge.
  - DONE: all_done=1. host_ack -> IDLE. host_go in DONE is ignored.
- Host writes:
  - Accepted only in IDLE or DONE; ignored in RUN.
  - host_we and host_go in the same IDLE cycle: the write lands and the run starts.
- Host reads:
  - Allowed in any state.
  - host_rdata_* shows the result buffer at host_raddr one cycle later.
  - A write-back and a host read of the same address in the same cycle return the old data.
- Read service (RUN only):
  - A request is ri_real & ri_imag sampled high; addr_in is latched on that edge.
  - data_ok pulses exactly one cycle, READ_LAT cycles after the sampling edge. x_*_out carries the latched entry during that cycle and holds it until the next response.
  - Only one request may be outstanding. A new request while one is pending is dropped and sets err.
  - ri_real != ri_imag sets err and is not served.
  - A request outside RUN is ignored.
- Write-back (RUN only):
  - wi_real & wi_imag writes X_*_in to the result buffer at addr_in on that edge; wr_count increments.
  - wi_real != wi_imag sets err and writes nothing.
  - A write and a read request in the same cycle are both honoured.
- Completion check:
  - On core_done in RUN, wr_count must equal 8; otherwise err sets.
  - wr_count wraps 7 -> 0 and clears on host_go.
- err clears only on reset.

Decomposition:
- Shared package holds DW, AW, the FSM state encoding (IDLE/RUN/DONE) and the depth constant.
- One sub-module, idft_sample_ram: 8xDW simple dual-port buffer with one write and one registered read port.
  - Instantiated four times: input real, input imag, result real, result imag.
- The FSM, request tracking and the READ_LAT shift register stay in idft_mem_server.

Test Plan:
- Load input[k] = 32'h100*(k+1) real and 32'h10*(k+1) imag, pulse host_go, attach a behavioural core (ri pulse -> wait data_ok -> write halved value):
  - result[k] real = 32'h80*(k+1), imag = 32'h8*(k+1).
  - all_done=1 after the 8th write.
  - err=0.
- READ_LAT=3, single request addr 5: data_ok is high exactly on the 3rd edge after sampling, for 1 cycle, with x_real_out = input[5].
- Second ri while the first is pending: only one data_ok pulse; err=1 and remains 1 until rst=0.
- ri_real=1, ri_imag=0: no data_ok; err=1. Separately, core_done after 6 writes: DONE entered, err=1.
- host_we to addr 2 during RUN: input[2] unchanged. After host_ack the block is in IDLE, and a write to addr 2 then succeeds.
- rst=0 mid-RUN after 3 writes:
  - core_start, busy and data_ok drop immediately without waiting for a clock edge.
  - FSM returns to IDLE.
  - result[0..2] are retained.
